// File: rtl/alarm_beep_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_beep_sequencer
//
// Purpose
//   Drives the alarm buzzer. A start pulse plays BEEPS tone bursts. Each burst
//   is ON_TICKS ticks of square-wave tone, and the bursts are separated by
//   OFF_TICKS ticks of silence. A tick prescaler (I_CLK cycles per tick), a
//   phase tick counter and a tone half-period divider are cleared on every
//   state entry, so every phase starts from a known point.
//
// Optional feature (compile-time macro): ALARM_SNOOZE_EN
//   When it is defined, snooze during ON/OFF enters a SNOOZE hold-off of
//   SNOOZE_TICKS ticks and then restarts the whole sequence from burst 0.
//   When it is undefined, the snooze port is present but has no effect, and no
//   SNOOZE state exists.
//
// Ports
//   I_CLK     in   1  system clock
//   rst_n     in   1  asynchronous reset, active low
//   start     in   1  one-cycle request to begin a sequence (ignored while busy)
//   stop      in   1  abort (level); has priority over start, snooze, phase end
//   snooze    in   1  snooze request (only with ALARM_SNOOZE_EN)
//   O_BUZZ    out  1  buzzer square wave, 0 outside ON
//   busy      out  1  high whenever the sequencer is not idle
//   beep_idx  out  8  0-based index of the current burst
//   done      out  1  one-cycle pulse on normal completion, aligned with busy falling
//
// Handshake: start is a single-cycle request sampled on I_CLK. There is no
// ready signal. A start that is sampled while busy is dropped.
// All outputs are registered.
// -----------------------------------------------------------------------------
module alarm_beep_sequencer #(
  parameter int TICK_DIV     = 100000,
  parameter int TONE_DIV     = 50000,
  parameter int ON_TICKS     = 200,
  parameter int OFF_TICKS    = 200,
  parameter int BEEPS        = 5,
  parameter int SNOOZE_TICKS = 5000
) (
  input  logic       I_CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       snooze,
  output logic       O_BUZZ,
  output logic       busy,
  output logic [7:0] beep_idx,
  output logic       done
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ON     = 2'd1,
    S_OFF    = 2'd2,
    S_SNOOZE = 2'd3
  } state_t;

  localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_TICKS  = (SNOOZE_TICKS > MAX_ON_OFF) ? SNOOZE_TICKS : MAX_ON_OFF;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  // The snooze input and the snooze length are deliberately left unused in this build.
  localparam int unused_snooze_ticks = SNOOZE_TICKS;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // The prescaler counts 0..TICK_DIV-1, the phase counter counts ticks
  // 0..N-1, and the tone divider counts 0..TONE_DIV/2-1.
  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int HALF = TONE_DIV / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [HW-1:0]   tone_q, tone_d;
  logic            buzz_d, busy_d, done_d;
  logic [7:0]      idx_d;
  logic [TW-1:0]   phase_last;
  logic            phase_end;

  // State register and all registered outputs.
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      tick_q   <= '0;
      tone_q   <= '0;
      O_BUZZ   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beep_idx <= 8'd0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      tone_q   <= tone_d;
      O_BUZZ   <= buzz_d;
      busy     <= busy_d;
      done     <= done_d;
      beep_idx <= idx_d;
    end
  end

  // Last tick index of the current phase.
  always_comb begin
    phase_last = '0;
    case (state_q)
      S_ON:     phase_last = TW'(ON_TICKS - 1);
      S_OFF:    phase_last = TW'(OFF_TICKS - 1);
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: phase_last = TW'(SNOOZE_TICKS - 1);
`endif
      default:  phase_last = '0;
    endcase
  end

  // A phase of N ticks ends on its N*TICK_DIV-th cycle. The transition then
  // happens on the following edge.
  assign phase_end = (pre_q == PW'(TICK_DIV - 1)) && (tick_q == phase_last);

  // Next-state logic and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = beep_idx;
    buzz_d  = 1'b0;
    done_d  = 1'b0;
    tone_d  = tone_q;
    tick_d  = tick_q;
    if (pre_q == PW'(TICK_DIV - 1)) begin
      pre_d  = '0;
      tick_d = tick_q + TW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        idx_d = 8'd0;
        if (start && !stop) begin
          state_d = S_ON;
        end
      end

      S_ON: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = 8'd0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_d = S_SNOOZE;
`endif
        end else if (phase_end) begin
          if (beep_idx == 8'(BEEPS - 1)) begin
            state_d = S_IDLE;
            idx_d   = 8'd0;
            done_d  = 1'b1;
          end else begin
            state_d = S_OFF;
          end
        end else if (tone_q == HW'(HALF - 1)) begin
          tone_d = '0;
          buzz_d = ~O_BUZZ;
        end else begin
          tone_d = tone_q + HW'(1);
          buzz_d = O_BUZZ;
        end
      end

      S_OFF: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = 8'd0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_d = S_SNOOZE;
`endif
        end else if (phase_end) begin
          state_d = S_ON;
          idx_d   = beep_idx + 8'd1;
        end
      end

`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = 8'd0;
        end else if (phase_end) begin
          // Snooze restarts the whole sequence from the first burst.
          state_d = S_ON;
          idx_d   = 8'd0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        idx_d   = 8'd0;
      end
    endcase

    // Each state entry restarts its counters, and IDLE holds them at zero.
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      pre_d  = '0;
      tick_d = '0;
      tone_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_alarm_beep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_beep_sequencer
//
// Directed-step bench with randomized timing. The reference model computes the
// expected outputs arithmetically from the number of edges since the start
// edge: bursts repeat with a period of ON+OFF cycles, and the tone level is
// (position / half-period) mod 2.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alarm_beep_sequencer;
  localparam int TICK_DIV     = 4;
  localparam int TONE_DIV     = 4;
  localparam int ON_TICKS     = 3;
  localparam int OFF_TICKS    = 2;
  localparam int BEEPS        = 2;
  localparam int SNOOZE_TICKS = 5;

  localparam int L_ON   = ON_TICKS * TICK_DIV;                     // 12
  localparam int L_OFF  = OFF_TICKS * TICK_DIV;                    // 8
  localparam int PERIOD = L_ON + L_OFF;                            // 20
  localparam int TOTAL  = BEEPS * L_ON + (BEEPS - 1) * L_OFF;      // 32
  localparam int L_SNZ  = SNOOZE_TICKS * TICK_DIV;                 // 20
  localparam int HALF   = TONE_DIV / 2;

  // Clock and reset block.
  logic       I_CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       O_BUZZ, busy, done;
  logic [7:0] beep_idx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 I_CLK = ~I_CLK;

  alarm_beep_sequencer #(
    .TICK_DIV(TICK_DIV), .TONE_DIV(TONE_DIV), .ON_TICKS(ON_TICKS),
    .OFF_TICKS(OFF_TICKS), .BEEPS(BEEPS), .SNOOZE_TICKS(SNOOZE_TICKS)
  ) dut (
    .I_CLK(I_CLK), .rst_n(rst_n), .start(start), .stop(stop), .snooze(snooze),
    .O_BUZZ(O_BUZZ), .busy(busy), .beep_idx(beep_idx), .done(done)
  );

  // Driver tasks. Inputs change at the falling edge. Outputs are sampled at
  // the falling edge that follows the next rising edge.
  task automatic tick();
    @(posedge I_CLK);
    @(negedge I_CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: k = number of edges since the start edge (k=0 at that edge).
  task automatic model(input int k, output logic eb, output logic ebz,
                       output logic ed, output logic [7:0] ei);
    int p;
    eb = 1'b0; ebz = 1'b0; ed = 1'b0; ei = 8'd0;
    if (k >= 0 && k < TOTAL) begin
      p   = k % PERIOD;
      eb  = 1'b1;
      ei  = 8'(k / PERIOD);
      ebz = (p < L_ON) && (((p / HALF) % 2) == 1);
    end else if (k == TOTAL) begin
      ed = 1'b1;
    end
  endtask

  task automatic check_all(input string tag, input logic eb, input logic ebz,
                           input logic ed, input logic [7:0] ei);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, ".buzz"}, {7'd0, O_BUZZ}, {7'd0, ebz});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, ed});
    chk({tag, ".idx"}, beep_idx, ei);
  endtask

  task automatic check_k(input string tag, input int k);
    logic eb, ebz, ed;
    logic [7:0] ei;
    model(k, eb, ebz, ed, ei);
    check_all($sformatf("%s@%0d", tag, k), eb, ebz, ed, ei);
  endtask

  task automatic fire_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_k(tag, 0);
  endtask

  // Advances from edge from_k to edge to_k. An input named *_at is asserted
  // for the single edge that follows the check of that k. After stop takes
  // effect, the expected outputs are idle.
  task automatic follow(input string tag, input int from_k, input int to_k,
                        input int start_at, input int stop_at, input int snooze_at);
    bit stopped = 1'b0;
    for (int k = from_k + 1; k <= to_k; k++) begin
      start  = (k - 1 == start_at);
      stop   = (k - 1 == stop_at);
      snooze = (k - 1 == snooze_at);
      tick();
      start = 1'b0; stop = 1'b0; snooze = 1'b0;
      if (k - 1 == stop_at) stopped = 1'b1;
      if (stopped) check_all($sformatf("%s@%0d", tag, k), 1'b0, 1'b0, 1'b0, 8'd0);
      else         check_k(tag, k);
    end
  endtask

  initial begin
    int r;
    // 1. Reset held low with random input activity.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start  = 1'($urandom_range(0, 1));
      stop   = 1'($urandom_range(0, 1));
      snooze = 1'($urandom_range(0, 1));
      tick();
      check_all("rst_hold", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    start = 1'b0; stop = 1'b0; snooze = 1'b0;
    rst_n = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    check_all("rst_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // 2. Full uninterrupted run.
    fire_start("run");
    follow("run", 0, TOTAL + 3, -1, -1, -1);

    // 3. Stop at a random point (spec example cycle 5 plus random points).
    fire_start("stop5");
    follow("stop5", 0, TOTAL + 2, -1, 5, -1);
    for (int t = 0; t < 3; t++) begin
      r = $urandom_range(0, TOTAL - 1);
      fire_start("stopr");
      follow("stopr", 0, TOTAL + 2, -1, r, -1);
    end

    // 4. A start while busy is ignored; start+stop in IDLE keeps the block idle.
    fire_start("restart");
    follow("restart", 0, TOTAL + 2, 10, -1, -1);
    r = $urandom_range(1, TOTAL - 1);
    fire_start("restartr");
    follow("restartr", 0, TOTAL + 2, r, -1, -1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_all("start_stop_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    check_all("start_stop_idle2", 1'b0, 1'b0, 1'b0, 8'd0);

    // 5. Snooze: once at an ON phase end, and once at a random point.
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check_all("snooze_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int t = 0; t < 2; t++) begin
      r = (t == 0) ? (L_ON - 1) : $urandom_range(0, TOTAL - 1);
      fire_start("snz");
`ifdef ALARM_SNOOZE_EN
      follow("snz_pre", 0, r, -1, -1, -1);
      for (int m = 0; m < L_SNZ; m++) begin
        // A snooze sampled while already snoozing is ignored.
        snooze = (m == 0) || (m == 3);
        tick();
        snooze = 1'b0;
        chk($sformatf("snz_hold@%0d.busy", m), {7'd0, busy}, 8'd1);
        chk($sformatf("snz_hold@%0d.buzz", m), {7'd0, O_BUZZ}, 8'd0);
        chk($sformatf("snz_hold@%0d.done", m), {7'd0, done}, 8'd0);
      end
      tick();
      check_k("snz_rerun", 0);
      follow("snz_rerun", 0, TOTAL + 2, -1, -1, -1);
`else
      follow("snz_off", 0, TOTAL + 2, -1, -1, r);
`endif
    end

    // 6. Asynchronous reset while the tone is high, then no activity until a new start.
    fire_start("arst");
    r = 2 + 4 * $urandom_range(0, 1) + $urandom_range(0, 1);
    follow("arst", 0, r, -1, -1, -1);
    #2 rst_n = 1'b0;
    #1 check_all("arst_now", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge I_CLK);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      snooze = 1'($urandom_range(0, 1));
      tick();
      snooze = 1'b0;
      check_all("arst_quiet", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    fire_start("arst_run");
    follow("arst_run", 0, TOTAL + 2, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog: the directed sequence is short, so this only fires if the bench stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
